// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline hazard unit with forwarding, stalls and long-op busy scoreboard
// Combinational forwarding/stall outputs; registered busy bits, in-flight count, sticky error and counters.
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 32,
  localparam int NREGS  = 2**REG_AW,
  localparam int OUT_W  = $clog2(MAX_OUT+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] writeregD,
  input  logic              regwriteD,
  input  logic              longopD,
  input  logic [1:0]        branchD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              longopE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              regwriteW,
  input  logic              ldone,
  input  logic [REG_AW-1:0] ldone_reg,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushE,
  output logic [NREGS-1:0]  busy,
  output logic [OUT_W-1:0]  outstanding,
  output logic              sb_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  sb_stall_cnt
);

  localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);
  localparam logic [NREGS-1:0] NOT_R0    = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] busy_q, busy_d, set_mask, clr_mask, busy_eff;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, sb_cnt_q, sb_cnt_d;
  logic             issue_e, done_valid, lwstall, branchstall, sbstall, raw, waw, cap, stall;
  logic [OUT_W:0]   out_plus_issue;

  assign forwardaD = (rsD != '0) && regwriteM && (rsD == writeregM);
  assign forwardbD = (rtD != '0) && regwriteM && (rtD == writeregM);

  assign forwardaE = ((rsE != '0) && regwriteM && (rsE == writeregM)) ? 2'b10 :
                     ((rsE != '0) && regwriteW && (rsE == writeregW)) ? 2'b01 : 2'b00;
  assign forwardbE = ((rtE != '0) && regwriteM && (rtE == writeregM)) ? 2'b10 :
                     ((rtE != '0) && regwriteW && (rtE == writeregW)) ? 2'b01 : 2'b00;

  assign lwstall     = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign branchstall = (branchD != 2'b00) &&
                       ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                        (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));

  assign issue_e = longopE && regwriteE && (writeregE != '0);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_e) set_mask[writeregE] = 1'b1;
    if (ldone)   clr_mask[ldone_reg] = 1'b1;
  end

  // A same-cycle completion frees the register: the file writes before the D read.
  assign busy_eff = ((busy_q & ~clr_mask) | set_mask) & NOT_R0;

  assign raw            = busy_eff[rsD] || busy_eff[rtD];
  assign waw            = regwriteD && busy_eff[writeregD];
  assign out_plus_issue = {1'b0, out_q} + {{OUT_W{1'b0}}, issue_e};
  assign cap            = longopD && (out_plus_issue >= (OUT_W+1)'(MAX_OUT));
  assign sbstall        = raw || waw || cap;
  assign stall          = lwstall || branchstall || sbstall;

  assign stallD = stall;
  assign stallF = stall;
  assign flushE = stall;

  // busy_q[0] never sets, so this also rejects completions to register 0.
  assign done_valid = ldone && busy_q[ldone_reg];

  always_comb begin
    busy_d = (busy_q & ~(done_valid ? clr_mask : '0)) | set_mask;
    busy_d = busy_d & NOT_R0;

    out_d = out_q;
    if (issue_e && !done_valid && (out_q != MAX_OUT_V))
      out_d = out_q + OUT_W'(1);
    else if (!issue_e && done_valid && (out_q != '0))
      out_d = out_q - OUT_W'(1);

    err_d = err_q || (ldone && !done_valid) || (issue_e && (out_q == MAX_OUT_V));

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    sb_cnt_d = sb_cnt_q;
    if (sbstall && (sb_cnt_q != '1)) sb_cnt_d = sb_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      sb_cnt_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      out_q       <= out_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      sb_cnt_q    <= sb_cnt_d;
    end
  end

  assign busy         = busy_q;
  assign outstanding  = out_q;
  assign sb_err       = err_q;
  assign stall_cnt    = stall_cnt_q;
  assign sb_stall_cnt = sb_cnt_q;

endmodule
